// File: rtl/mem_access_unit_if.sv
// Request bus between the EX/MEM pipeline register and the MEM-stage load/store
// controller. The slave side back-pressures the requester with stall.
interface mem_access_unit_if #(
  parameter int ADDR_W = 8
);
  logic              req_valid;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W+1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [4:0]        req_rd;
  logic              stall;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_rd,
    input  stall
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_rd,
    output stall
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller in front of a word-wide sram. Sub-word stores
// run as a read cycle followed by a write of the merged word.
module mem_access_unit #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_access_unit_if.slave  req,
  output logic              CSram,
  output logic [ADDR_W-1:0] Direc,
  output logic [31:0]       Datain,
  output logic              LeerMem,
  output logic              EscrMem,
  input  logic [31:0]       Dataout,
  output logic              wb_valid,
  output logic [31:0]       wb_data,
  output logic [4:0]        wb_rd,
  output logic              misalign_err
);

  typedef enum logic {IDLE, RMW_WR} state_t;

  function automatic logic aligned_f(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 1'b1;
      2'b01:   return ~off[0];
      2'b10:   return (off == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] off, input logic uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (size)
      2'b00:   return uns ? {24'h0, b} : 32'(b);
      2'b01:   return uns ? {16'h0, h} : 32'(h);
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] off, input logic [31:0] wdata);
    logic [31:0] mask;
    mask = ((size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << {off, 3'b000};
    return (word & ~mask) | ((wdata << {off, 3'b000}) & mask);
  endfunction

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       merged_q;
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        off;
  logic              ok, go, ld_acc, rmw_start;
  logic              cs, rd_en, wr_en;

  assign word_idx  = req.req_addr[ADDR_W+1:2];
  assign off       = req.req_addr[1:0];
  assign ok        = aligned_f(req.req_size, off);
  assign go        = (state == IDLE) && req.req_valid;
  assign ld_acc    = go && ok && !req.req_we;
  assign rmw_start = go && ok && req.req_we && (req.req_size != 2'b10);

  // Stage 0: sram strobes decoded from state and the presented request
  always_comb begin
    cs        = 1'b0;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    req.stall = 1'b0;
    Direc     = word_idx;
    Datain    = req.req_wdata;
    case (state)
      IDLE: begin
        if (go && ok) begin
          cs = 1'b1;
          if (!req.req_we) begin
            rd_en = 1'b1;
          end else if (req.req_size == 2'b10) begin
            wr_en = 1'b1;
          end else begin
            rd_en     = 1'b1;
            req.stall = 1'b1;
          end
        end
      end
      RMW_WR: begin
        cs     = 1'b1;
        wr_en  = 1'b1;
        Direc  = addr_q;
        Datain = merged_q;
      end
    endcase
  end

  // Reset kills the strobes immediately so an in-flight write is dropped.
  assign CSram   = cs & rst_n;
  assign LeerMem = rd_en & rst_n;
  assign EscrMem = wr_en & rst_n;

  // Stage 1: FSM and MEM/WB register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wb_valid     <= 1'b0;
      wb_data      <= 32'h0;
      wb_rd        <= 5'h0;
      misalign_err <= 1'b0;
    end else begin
      wb_valid     <= ld_acc;
      misalign_err <= go && !ok;
      if (ld_acc) begin
        wb_data <= extend_load(Dataout, req.req_size, off, req.req_unsigned);
        wb_rd   <= req.req_rd;
      end
      case (state)
        IDLE:    if (rmw_start) state <= RMW_WR;
        RMW_WR:  state <= IDLE;
      endcase
    end
  end

  // Stage 1: read-modify-write holding registers (data only, no reset)
  always_ff @(posedge clk) begin
    if (rmw_start) begin
      addr_q   <= word_idx;
      merged_q <= merge_store(Dataout, req.req_size, off, req.req_wdata);
    end
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store controller sitting directly upstream of the data sram.
- Takes byte-addressed load/store requests from the EX/MEM pipeline register and drives the sram port (CSram, Direc, Datain, LeerMem, EscrMem).
- Performs sub-word stores as a two-cycle read-modify-write, because the sram writes whole 32-bit words only.
- Extends load data and registers the result, with its destination register, into the MEM/WB pipeline register.

Parameters:
- ADDR_W, 8, word-address width of the sram; byte address is ADDR_W+2 bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present from EX/MEM.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word; 11 is illegal and handled as misaligned.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  ADDR_W+2  byte address; [1:0] is the byte offset, [ADDR_W+1:2] is the word index.
- req_wdata  in  32  store data, right-aligned.
- req_rd  in  5  load destination register.
- stall  out  1  upstream must hold the request and freeze the pipeline while high.
- CSram  out  1  sram chip select.
- Direc  out  ADDR_W  sram word address.
- Datain  out  32  sram write data.
- LeerMem  out  1  sram read enable.
- EscrMem  out  1  sram write enable.
- Dataout  in  32  sram combinational read data.
- wb_valid  out  1  load result valid in MEM/WB.
- wb_data  out  32  extended load data.
- wb_rd  out  5  destination register of wb_data.
- misalign_err  out  1  one-cycle pulse flagging a rejected misaligned request.

Behaviour:
- Reset values: state=IDLE, wb_valid=0, wb_data=0, wb_rd=0, misalign_err=0.
- While rst_n is low, CSram, LeerMem and EscrMem are forced to 0 combinationally.
- Lanes are little-endian: offset 0 = Datain/Dataout bits [7:0].
- Alignment: halfword needs offset[0]=0; word needs offset=00. A request is accepted when req_valid=1 and stall=0.

State IDLE:
- Load: CSram=1, LeerMem=1, Direc=word index, stall=0.
  - Next edge: wb_valid=1, wb_rd=req_rd.
  - wb_data = selected lane, zero- or sign-extended from bit 7 (byte) or bit 15 (half); word loads pass through unchanged.
  - Load-to-WB latency is 1 cycle.
- Word store: CSram=1, EscrMem=1, Datain=req_wdata, stall=0. The sram writes on that edge; wb_valid=0 next cycle.
- Sub-word store, read cycle:
  - CSram=1, LeerMem=1, EscrMem=0, stall=1.
  - On the edge: register word index into addr_q; register merged = Dataout with the target lane(s) replaced by req_wdata[7:0] or [15:0]; go to RMW_WR.
- Misaligned or size 11:
  - No sram strobes, stall=0, request consumed.
  - Next edge: misalign_err=1 for one cycle, wb_valid=0. Stores do not write.
- No request: all strobes 0, wb_valid=0 next edge.

State RMW_WR:
- CSram=1, EscrMem=1, LeerMem=0, Direc=addr_q, Datain=merged_q, stall=0.
- The held request is consumed on this edge; req_* inputs are ignored; return to IDLE.
- A sub-word store therefore occupies 2 cycles; back-to-back requests are supported with no bubble after RMW_WR.

Boundary conditions:
- wb_valid deasserts the cycle after any non-load or bubble.
- wb_data holds its last value when wb_valid=0.
- Reset asserted during RMW_WR:
  - Strobes drop immediately, so the write is lost.
  - State returns to IDLE; no pending state survives reset.
- Highest address (word index 2^ADDR_W-1, offset 11) is legal for byte access; there is no wrap-around, the address is never incremented.

Test Plan:
- Word store 0xDEADBEEF to byte addr 0x010, then word load from 0x010 -> EscrMem pulses 1 cycle at Direc=0x04; next load gives wb_valid=1, wb_data=0xDEADBEEF, wb_rd=req_rd, stall never asserted.
- With word 0x04 = 0xDEADBEEF, byte store 0x55 to addr 0x012 -> stall=1 for 1 cycle, then EscrMem with Datain=0xDE55BEEF; reload of the word returns 0xDE55BEEF.
- Byte loads from 0x013 (0xDE): signed -> 0xFFFFFFDE, unsigned -> 0x000000DE; halfword load from 0x010 (0xBEEF), signed -> 0xFFFFBEEF.
- Halfword store to 0x011 and word load from 0x012 -> misalign_err pulses one cycle each, no EscrMem, wb_valid=0, sram word unchanged.
- Sub-word store followed immediately by a load of the same word -> load issues in the cycle after RMW_WR and returns the merged value, with no extra bubble.
- Assert rst_n=0 mid-RMW_WR -> EscrMem drops the same cycle, target word keeps its old value, state=IDLE, all outputs at reset values.
